// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, halt opcode and instruction field positions
package fetch_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, VALID, HALT} state_t;
    localparam logic [5:0] HALT_OP_DEF = 6'h3F;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
endpackage

// File: rtl/instr_fetch_seq_if.sv
// instr_fetch_seq_if: byte memory read bus plus instruction handoff to decode
//   master = fetch side (drives reads and the instruction), slave = memory/decode side
interface instr_fetch_seq_if #(parameter int ADDR_W = 7);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_pc;
    logic [31:0]       instr;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       immediate;
    modport master (
        output mem_rd_en, mem_addr, inst_valid, inst_pc, instr, op, rs, rt, rd, immediate,
        input  mem_rdata, inst_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, inst_valid, inst_pc, instr, op, rs, rt, rd, immediate,
        output mem_rdata, inst_ready
    );
endinterface

// File: rtl/instr_word_assembler.sv
// instr_word_assembler: captures bytes big-endian into a word and splits its fields
//   cap_en/cap_idx/rdata: byte capture strobe, slot (0 = bits 31:24) and data
//   word/op/rs/rt/rd/immediate: last completed word and its fields
module instr_word_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_en,
    input  logic [1:0]  cap_idx,
    input  logic [7:0]  rdata,
    output logic [31:0] word,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] immediate
);
    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic [4:0]  sh;
    always_comb begin
        // ~cap_idx equals 3 - cap_idx, so slot 0 lands in the top byte
        sh    = {~cap_idx, 3'b000};
        asm_d = (asm_q & ~(32'hFF << sh)) | (32'(rdata) << sh);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
            word  <= '0;
        end else if (cap_en) begin
            asm_q <= asm_d;
            if (cap_idx == 2'd3) word <= asm_d;
        end
    end
    assign op        = word[OP_MSB:OP_LSB];
    assign rs        = word[RS_MSB:RS_LSB];
    assign rt        = word[RT_MSB:RT_LSB];
    assign rd        = word[RD_MSB:RD_LSB];
    assign immediate = word[IMM_MSB:IMM_LSB];
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: PC owner issuing four byte reads per instruction and handing words to decode
//   run: start/continue fetching; redirect_valid/redirect_pc: branch/jump target
//   halted: parked on the halt opcode; busy: reads in progress; bus: memory + decode handshake
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [5:0]  HALT_OP  = HALT_OP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        busy,
    instr_fetch_seq_if.master bus
);
    state_t      state, nxt;
    logic [31:0] pc, pc_nxt, word;
    logic [1:0]  issue_idx, idx_nxt, cap_idx;
    logic        rd_pend;
    logic [5:0]  op;
    always_comb begin
        nxt     = state;
        pc_nxt  = pc;
        idx_nxt = issue_idx;
        if (redirect_valid) begin
            pc_nxt  = redirect_pc & ~32'h3;
            nxt     = run ? ISSUE : IDLE;
            idx_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt     = run ? ISSUE : IDLE;
                    idx_nxt = '0;
                end
                ISSUE: begin
                    idx_nxt = issue_idx + 2'd1;
                    nxt     = (issue_idx == 2'd3) ? DRAIN : ISSUE;
                end
                DRAIN: nxt = VALID;
                VALID: if (bus.inst_ready) begin
                    pc_nxt  = pc + 32'd4;
                    nxt     = (op == HALT_OP) ? HALT : (run ? ISSUE : IDLE);
                    idx_nxt = '0;
                end
                default: nxt = state;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            issue_idx <= '0;
            cap_idx   <= '0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= nxt;
            pc        <= pc_nxt;
            issue_idx <= idx_nxt;
            // a redirect cancels the read issued this cycle so its byte is never captured
            rd_pend   <= (state == ISSUE) && !redirect_valid;
            cap_idx   <= redirect_valid ? 2'd0 : (rd_pend ? cap_idx + 2'd1 : cap_idx);
        end
    end
    instr_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (rd_pend),
        .cap_idx   (cap_idx),
        .rdata     (bus.mem_rdata),
        .word      (word),
        .op        (op),
        .rs        (bus.rs),
        .rt        (bus.rt),
        .rd        (bus.rd),
        .immediate (bus.immediate)
    );
    assign bus.op         = op;
    assign bus.instr      = word;
    assign bus.mem_rd_en  = (state == ISSUE);
    assign bus.mem_addr   = (state == ISSUE) ? pc[ADDR_W-1:0] + ADDR_W'(issue_idx) : '0;
    assign bus.inst_valid = (state == VALID);
    assign bus.inst_pc    = (state == VALID) ? pc : '0;
    assign halted         = (state == HALT);
    assign busy           = (state == ISSUE) || (state == DRAIN);
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: scoreboard bench for instr_fetch_seq with a byte memory model
module tb_instr_fetch_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halted, busy;
    logic [7:0]  mem [128];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  addr_q [$];
    logic [63:0] inst_q [$];
    instr_fetch_seq_if #(.ADDR_W(7)) bus ();
    instr_fetch_seq #(.ADDR_W(7), .RESET_PC(32'h0), .HALT_OP(6'h3F)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .busy           (busy),
        .bus            (bus)
    );
    always #5 clk = ~clk;
    // memory answers one cycle after the strobe; garbage otherwise so stray captures show up
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : 8'($urandom);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] word_at(input logic [31:0] p);
        logic [6:0] a;
        a = p[6:0];
        return {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
    endfunction
    task automatic exp_fetch(input logic [31:0] p);
        for (int i = 0; i < 4; i++) addr_q.push_back(7'(p[6:0] + 7'(i)));
        inst_q.push_back({p, word_at(p)});
    endtask
    task automatic wait_valid();
        for (int i = 0; i < 20 && !bus.inst_valid; i++) cyc();
        chk("valid_timeout", 32'(bus.inst_valid), 32'd1);
    endtask
    task automatic handoff(input logic run_after);
        run = run_after;
        bus.inst_ready = 1'b1;
        cyc();
        bus.inst_ready = 1'b0;
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.mem_rd_en) begin
            if (addr_q.size() == 0) chk("rd_unexpected", 32'(bus.mem_rd_en), 32'd0);
            else chk("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
        end
        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            if (inst_q.size() == 0) chk("xfer_unexpected", 32'(bus.inst_valid), 32'd0);
            else begin
                logic [63:0] e;
                e = inst_q.pop_front();
                chk("inst_pc", bus.inst_pc, e[63:32]);
                chk("instr", bus.instr, e[31:0]);
                chk("op", 32'(bus.op), 32'(e[31:26]));
                chk("rs", 32'(bus.rs), 32'(e[25:21]));
                chk("rt", 32'(bus.rt), 32'(e[20:16]));
                chk("rd", 32'(bus.rd), 32'(e[15:11]));
                chk("imm", 32'(bus.immediate), 32'(e[15:0]));
            end
        end
    end
    initial begin
        logic [31:0] held_instr;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
        mem[8] = 8'hFC; mem[16] = 8'h20; mem[124] = 8'h11;
        bus.inst_ready = 1'b0;
        #12;
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        // first fetch from reset PC, decode stalled for 10 cycles after the word appears
        exp_fetch(32'h0);
        run = 1'b1;
        repeat (5) cyc();
        chk("lat_cycle4_valid", 32'(bus.inst_valid), 32'd0);
        cyc();
        chk("lat_cycle5_valid", 32'(bus.inst_valid), 32'd1);
        chk("t1_instr", bus.instr, 32'h8C220004);
        held_instr = bus.instr;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_instr", bus.instr, held_instr);
            chk("stall_pc", bus.inst_pc, 32'h0);
            chk("stall_rd_en", 32'(bus.mem_rd_en), 32'd0);
        end
        // next fetch at 4 is redirected to 0x13 while issuing its third byte
        for (int i = 4; i < 7; i++) addr_q.push_back(7'(i));
        handoff(1'b1);
        chk("t2_addr4", 32'(bus.mem_addr), 32'd4);
        cyc();
        cyc();
        exp_fetch(32'h10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h13;
        cyc();
        redirect_valid = 1'b0;
        chk("t3_addr16", 32'(bus.mem_addr), 32'd16);
        wait_valid();
        handoff(1'b0);
        // wrap: 124..127 then pc 128 reads from address 0
        exp_fetch(32'd124);
        run = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd124;
        cyc();
        redirect_valid = 1'b0;
        wait_valid();
        exp_fetch(32'd128);
        handoff(1'b1);
        chk("wrap_addr0", 32'(bus.mem_addr), 32'd0);
        wait_valid();
        handoff(1'b0);
        // halt opcode parks the sequencer until a redirect
        exp_fetch(32'h8);
        run = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        cyc();
        redirect_valid = 1'b0;
        wait_valid();
        handoff(1'b1);
        chk("halted", 32'(halted), 32'd1);
        repeat (5) cyc();
        chk("halt_stay", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_valid", 32'(bus.inst_valid), 32'd0);
        exp_fetch(32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        chk("unhalt", 32'(halted), 32'd0);
        wait_valid();
        handoff(1'b0);
        // async reset during the third read of a fetch at 4
        addr_q.push_back(7'd4);
        addr_q.push_back(7'd5);
        run = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_instr", bus.instr, 32'h0);
        chk("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
        cyc();
        exp_fetch(32'h0);
        rst_n = 1'b1;
        cyc();
        wait_valid();
        handoff(1'b0);
        repeat (3) cyc();
        chk("addr_q_left", addr_q.size(), 32'd0);
        chk("inst_q_left", inst_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
